svc_pix_fb: RTL and testbench

- Pixel-stream-to-framebuffer writer: accepts the valid/ready pixel stream (rgb, x, y) and writes pixels into framebuffer memory as AXI4 INCR write bursts.
- It is the write-side counterpart of the framebuffer-to-pixel reader.
- It is used by renderers and test-pattern sources to fill the buffer that the VGA path scans out.
- One pixel occupies one AXI data word.

---
 rtl/svc_pix_fb.sv | 274 +++++++++++++++++++++++++++
 tb/tb_svc_pix_fb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_pix_fb.sv
// ---------------------------------------------------------------------------
// svc_pix_fb -- pixel stream to framebuffer writer.
//
// Collects runs of address-contiguous pixels from a valid/ready pixel stream
// and writes each run to framebuffer memory as one AXI4 INCR write burst.
// One pixel occupies one AXI data word: {zero pad, red, grn, blu}.
// Only one burst is in flight at any time, so AXI ordering is trivial.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   s_pix_*               pixel stream in (valid/ready, rgb, x, y)
//   h_visible             line length in pixels, static while busy
//   m_axi_aw*             write address channel (INCR bursts, id 0)
//   m_axi_w*              write data channel (full strobes)
//   m_axi_b*              write response channel (bid ignored)
//   busy                  a burst is being collected or written
//   wr_error              sticky flag, set by any non-OKAY response
// ---------------------------------------------------------------------------
module svc_pix_fb #(
    parameter int H_WIDTH        = 12,
    parameter int V_WIDTH        = 12,
    parameter int COLOR_WIDTH    = 4,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_BURST      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_pix_valid,
    input  logic [COLOR_WIDTH-1:0]      s_pix_red,
    input  logic [COLOR_WIDTH-1:0]      s_pix_grn,
    input  logic [COLOR_WIDTH-1:0]      s_pix_blu,
    input  logic [H_WIDTH-1:0]          s_pix_x,
    input  logic [V_WIDTH-1:0]          s_pix_y,
    output logic                        s_pix_ready,
    input  logic [H_WIDTH-1:0]          h_visible,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready,
    output logic                        busy,
    output logic                        wr_error
);

    localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_W      = $clog2(MAX_BURST) + 1;
    localparam int IDX_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // Bursts must not cross a 4 KB page; narrow address spaces use the whole width.
    localparam int PAGE_BITS  = (AXI_ADDR_WIDTH < 12) ? AXI_ADDR_WIDTH : 12;

    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]          CNT_MAX    = CNT_W'(MAX_BURST);
    localparam logic [H_WIDTH-1:0]        H_ONE      = H_WIDTH'(1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4
    } state_t;

    // Byte address of pixel (x, y); the index wraps silently at the address width.
    function automatic logic [AXI_ADDR_WIDTH-1:0] pix_byte_addr(
        input logic [H_WIDTH-1:0] x,
        input logic [V_WIDTH-1:0] y,
        input logic [H_WIDTH-1:0] hv
    );
        logic [AXI_ADDR_WIDTH-1:0] idx;
        idx = AXI_ADDR_WIDTH'(y) * AXI_ADDR_WIDTH'(hv) + AXI_ADDR_WIDTH'(x);
        return idx << BYTE_SHIFT;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [CNT_W-1:0]          count_r;
    logic [CNT_W-1:0]          beat_r;
    logic [AXI_ADDR_WIDTH-1:0] start_addr_r;
    logic [AXI_ADDR_WIDTH-1:0] next_addr_r;
    logic                      wr_error_r;
    logic [AXI_DATA_WIDTH-1:0] buf_r [MAX_BURST];

    logic [AXI_ADDR_WIDTH-1:0] pix_addr_s;
    logic [AXI_ADDR_WIDTH-1:0] pix_addr_inc_s;
    logic [AXI_DATA_WIDTH-1:0] pix_word_s;
    logic [CNT_W-1:0]          count_inc_s;
    logic [IDX_W-1:0]          wr_idx_s;
    logic                      contig_s;
    logic                      x_last_s;
    logic                      page_end_s;
    logic                      close_s;
    logic                      beat_last_s;
    logic                      pix_ready_s;
    logic                      accept_s;
    logic                      awvalid_s;
    logic                      wvalid_s;
    logic                      bready_s;
    logic                      unused_s;

    // Pixel addressing, contiguity and burst-closure decode.
    always_comb begin
        pix_addr_s     = pix_byte_addr(s_pix_x, s_pix_y, h_visible);
        pix_addr_inc_s = pix_addr_s + BEAT_BYTES;
        pix_word_s     = AXI_DATA_WIDTH'({s_pix_red, s_pix_grn, s_pix_blu});
        contig_s       = (pix_addr_s == next_addr_r);
        x_last_s       = (s_pix_x == (h_visible - H_ONE));
        page_end_s     = (pix_addr_inc_s[PAGE_BITS-1:0] == {PAGE_BITS{1'b0}});
        if (state_r == ST_IDLE) begin
            count_inc_s = CNT_ONE;
            wr_idx_s    = {IDX_W{1'b0}};
        end else begin
            count_inc_s = count_r + CNT_ONE;
            wr_idx_s    = count_r[IDX_W-1:0];
        end
        // Closure looks at the pixel being accepted, so a lone pixel can close.
        close_s     = (count_inc_s == CNT_MAX) || x_last_s || page_end_s;
        beat_last_s = (beat_r == (count_r - CNT_ONE));
    end

    assign accept_s = s_pix_valid && pix_ready_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = close_s ? ST_AW : ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    state_nxt_s = close_s ? ST_AW : ST_FILL;
                end else if (s_pix_valid) begin
                    // Non-contiguous pixel: close now, it opens the next burst.
                    state_nxt_s = ST_AW;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    state_nxt_s = ST_W;
                end else begin
                    state_nxt_s = ST_AW;
                end
            end
            ST_W: begin
                if (m_axi_wready && beat_last_s) begin
                    state_nxt_s = ST_B;
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        pix_ready_s = 1'b0;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        case (state_r)
            ST_IDLE: pix_ready_s = ~rst;
            ST_FILL: pix_ready_s = contig_s && ~rst;
            ST_AW:   awvalid_s   = 1'b1;
            ST_W:    wvalid_s    = 1'b1;
            ST_B:    bready_s    = 1'b1;
            default: pix_ready_s = 1'b0;
        endcase
    end

    // Burst bookkeeping: start address, expected next address, beat counters, error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r      <= {CNT_W{1'b0}};
            beat_r       <= {CNT_W{1'b0}};
            start_addr_r <= {AXI_ADDR_WIDTH{1'b0}};
            next_addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
            wr_error_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        start_addr_r <= pix_addr_s;
                        next_addr_r  <= pix_addr_inc_s;
                        count_r      <= CNT_ONE;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        next_addr_r <= pix_addr_inc_s;
                        count_r     <= count_inc_s;
                    end
                end
                ST_AW: beat_r <= {CNT_W{1'b0}};
                ST_W: begin
                    if (m_axi_wready) begin
                        beat_r <= beat_r + CNT_ONE;
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        count_r <= {CNT_W{1'b0}};
                        if (m_axi_bresp != 2'b00) begin
                            wr_error_r <= 1'b1;
                        end
                    end
                end
                default: count_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    // Pixel data buffer; left unreset so it can map onto RAM, every beat is written before being read.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_r[wr_idx_s] <= pix_word_s;
        end
    end

    assign s_pix_ready   = pix_ready_s;
    assign m_axi_awvalid = awvalid_s;
    assign m_axi_awaddr  = start_addr_r;
    assign m_axi_awid    = {AXI_ID_WIDTH{1'b0}};
    assign m_axi_awlen   = 8'(count_r - CNT_ONE);
    assign m_axi_awsize  = 3'(BYTE_SHIFT);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = wvalid_s;
    assign m_axi_wdata   = buf_r[beat_r[IDX_W-1:0]];
    assign m_axi_wstrb   = {(AXI_DATA_WIDTH/8){1'b1}};
    assign m_axi_wlast   = wvalid_s && beat_last_s;
    assign m_axi_bready  = bready_s;
    assign busy          = (state_r != ST_IDLE);
    assign wr_error      = wr_error_r;

    // The response ID carries no information with a single outstanding burst.
    assign unused_s = ^m_axi_bid;

endmodule

// File: tb/tb_svc_pix_fb.sv
// Scoreboard bench for svc_pix_fb: stimulus pushes the expected AW, W and B
// outcomes into queues; a monitor pops and compares when the DUT presents them.
module tb_svc_pix_fb;

    logic        clk;
    logic        rst;
    logic        s_pix_valid;
    logic [3:0]  s_pix_red, s_pix_grn, s_pix_blu;
    logic [11:0] s_pix_x, s_pix_y;
    logic        s_pix_ready;
    logic [11:0] h_visible;
    logic        m_axi_awvalid, m_axi_awready;
    logic [15:0] m_axi_awaddr;
    logic [3:0]  m_axi_awid;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid, m_axi_wready;
    logic [15:0] m_axi_wdata;
    logic [1:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid;
    logic [3:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bready;
    logic        busy, wr_error;

    svc_pix_fb dut (
        .clk(clk), .rst(rst),
        .s_pix_valid(s_pix_valid), .s_pix_red(s_pix_red), .s_pix_grn(s_pix_grn),
        .s_pix_blu(s_pix_blu), .s_pix_x(s_pix_x), .s_pix_y(s_pix_y),
        .s_pix_ready(s_pix_ready), .h_visible(h_visible),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bready(m_axi_bready), .busy(busy), .wr_error(wr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_aw_q [$];   // {awaddr, awlen}
    logic [15:0] exp_w_q  [$];
    logic [1:0]  bresp_q  [$];
    logic        exp_err_q[$];
    logic        exp_err_sticky = 1'b0;
    logic        stall_en = 1'b0;

    // monitor state
    int          w_beat = 0;
    logic [7:0]  cur_len = 8'd0;
    logic        aw_hold = 1'b0, w_hold = 1'b0, err_pend = 1'b0, err_exp = 1'b0;
    logic [23:0] aw_prev;
    logic [16:0] w_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic push_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] resp);
        exp_aw_q.push_back({addr, len});
        bresp_q.push_back(resp);
        if (resp != 2'b00) exp_err_sticky = 1'b1;
        exp_err_q.push_back(exp_err_sticky);
    endtask

    // Called at posedge+1; returns after the pixel is accepted, again at posedge+1.
    task automatic send_pix(input int x, input int y, input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b, output int waits);
        exp_w_q.push_back({4'h0, r, g, b});
        s_pix_valid = 1'b1;
        s_pix_x = 12'(x); s_pix_y = 12'(y);
        s_pix_red = r; s_pix_grn = g; s_pix_blu = b;
        waits = 0;
        forever begin
            @(negedge clk);
            if (s_pix_ready) break;
            waits++;
            if (waits > 500) begin
                fail_now("pixel accept timeout");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        s_pix_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_aw_q.size() != 0 || exp_w_q.size() != 0 ||
                    exp_err_q.size() != 0 || err_pend) && n < 3000);
        if (n >= 3000) fail_now("idle timeout");
        check("queues drained", 32'(exp_aw_q.size() + exp_w_q.size() + exp_err_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Ready generators: always ready unless stalling is enabled.
    initial begin
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_axi_awready = stall_en ? ($urandom % 3 == 0) : 1'b1;
            m_axi_wready  = stall_en ? ($urandom % 2 == 0) : 1'b1;
        end
    end

    // Write-response generator: answers each completed burst with the next queued bresp.
    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        m_axi_bid    = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                int n;
                @(posedge clk); #1;
                m_axi_bresp  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
                m_axi_bvalid = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!m_axi_bready && !rst && n < 100);
                if (n >= 100) fail_now("bready timeout");
                @(posedge clk); #1;
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end
        end
    end

    // Monitor: compares every AXI handshake against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_hold = 1'b0; w_hold = 1'b0; err_pend = 1'b0;
            end else begin
                if (err_pend) begin
                    check("wr_error after B", 32'(wr_error), 32'(err_exp));
                    err_pend = 1'b0;
                end
                if (aw_hold) check("aw stable in stall", {7'd0, m_axi_awvalid, m_axi_awaddr, m_axi_awlen},
                                   {7'd0, 1'b1, aw_prev});
                if (w_hold) check("w stable in stall", {14'd0, m_axi_wvalid, m_axi_wlast, m_axi_wdata},
                                  {14'd0, 1'b1, w_prev});
                aw_hold = 1'b0;
                w_hold  = 1'b0;
                if (m_axi_awvalid) begin
                    if (m_axi_awready) begin
                        if (exp_aw_q.size() == 0) fail_now("unexpected AW");
                        else begin
                            logic [23:0] e;
                            e = exp_aw_q.pop_front();
                            check("awaddr", 32'(m_axi_awaddr), 32'(e[23:8]));
                            check("awlen", 32'(m_axi_awlen), 32'(e[7:0]));
                            check("aw id/size/burst", {23'd0, m_axi_awid, m_axi_awsize, m_axi_awburst},
                                  {23'd0, 4'h0, 3'd1, 2'b01});
                            cur_len = e[7:0];
                            w_beat  = 0;
                        end
                    end else begin
                        aw_hold = 1'b1;
                        aw_prev = {m_axi_awaddr, m_axi_awlen};
                    end
                end
                if (m_axi_wvalid) begin
                    if (m_axi_wready) begin
                        if (exp_w_q.size() == 0) fail_now("unexpected W beat");
                        else begin
                            check("wdata", 32'(m_axi_wdata), 32'(exp_w_q.pop_front()));
                            check("wlast", 32'(m_axi_wlast), 32'(w_beat == int'(cur_len)));
                            check("wstrb", 32'(m_axi_wstrb), 32'd3);
                            w_beat++;
                        end
                    end else begin
                        w_hold = 1'b1;
                        w_prev = {m_axi_wlast, m_axi_wdata};
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    if (exp_err_q.size() == 0) fail_now("unexpected B");
                    else begin
                        err_exp  = exp_err_q.pop_front();
                        err_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int beats;
        int n;
        rst = 1'b1;
        s_pix_valid = 1'b0;
        s_pix_red = 4'h0; s_pix_grn = 4'h0; s_pix_blu = 4'h0;
        s_pix_x = 12'd0; s_pix_y = 12'd0;
        h_visible = 12'd640;
        #2;
        check("ready in reset", 32'(s_pix_ready), 32'd0);
        check("reset axi valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        check("reset wlast/busy/err", {29'd0, m_axi_wlast, busy, wr_error}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("ready after reset", 32'(s_pix_ready), 32'd1);
        check("busy after reset", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Two full bursts along row 0.
        h_visible = 12'd640;
        push_burst(16'h0000, 8'd15, 2'b00);
        push_burst(16'h0020, 8'd15, 2'b00);
        for (int x = 0; x < 32; x++) send_pix(x, 0, 4'hA, 4'h5, 4'(x + 3), w);
        wait_idle();

        // End of line closes a burst.
        h_visible = 12'd10;
        push_burst(16'h0034, 8'd3, 2'b00);
        push_burst(16'h003C, 8'd9, 2'b00);
        for (int x = 6; x < 10; x++) send_pix(x, 2, 4'h1, 4'(x), 4'hF, w);
        for (int x = 0; x < 10; x++) send_pix(x, 3, 4'h2, 4'hC, 4'(x), w);
        wait_idle();

        // Non-contiguous pixel is held and starts the next burst.
        push_burst(16'h0000, 8'd1, 2'b00);
        push_burst(16'h000A, 8'd4, 2'b00);
        send_pix(0, 0, 4'h3, 4'h3, 4'h3, w);
        check("x0 accepted at once", 32'(w), 32'd0);
        send_pix(1, 0, 4'h4, 4'h4, 4'h4, w);
        check("x1 contiguous accepted", 32'(w), 32'd0);
        send_pix(5, 0, 4'h5, 4'h6, 4'h7, w);
        check("x5 held while busy", 32'(w >= 3), 32'd1);
        for (int x = 6; x < 10; x++) send_pix(x, 0, 4'h8, 4'(x), 4'h1, w);
        wait_idle();

        // 4 KB boundary split: index 2046 = 35*57 + 51.
        h_visible = 12'd57;
        push_burst(16'h0FFC, 8'd1, 2'b00);
        push_burst(16'h1000, 8'd3, 2'b00);
        for (int x = 51; x < 57; x++) send_pix(x, 35, 4'h9, 4'(x), 4'hE, w);
        wait_idle();

        // Random AW/W stalls, error response on the second burst.
        h_visible = 12'd8;
        stall_en = 1'b1;
        push_burst(16'h0010, 8'd7, 2'b00);
        push_burst(16'h0020, 8'd7, 2'b10);
        for (int x = 0; x < 8; x++) send_pix(x, 1, 4'hB, 4'(x), 4'h2, w);
        for (int x = 0; x < 8; x++) send_pix(x, 2, 4'hC, 4'h7, 4'(x), w);
        wait_idle();
        stall_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wr_error sticky", 32'(wr_error), 32'd1);

        // Reset in the middle of the W phase abandons the burst.
        push_burst(16'h0000, 8'd7, 2'b00);
        for (int x = 0; x < 8; x++) send_pix(x, 0, 4'hD, 4'(x), 4'h0, w);
        s_pix_valid = 1'b0;
        beats = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (m_axi_wvalid && m_axi_wready) beats++;
        end while (beats < 3 && n < 200);
        if (n >= 200) fail_now("W phase timeout");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst: valids drop", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        check("rst: busy drops", 32'(busy), 32'd0);
        check("rst: ready low", 32'(s_pix_ready), 32'd0);
        check("rst: wr_error cleared", 32'(wr_error), 32'd0);
        exp_aw_q.delete(); exp_w_q.delete(); bresp_q.delete(); exp_err_q.delete();
        exp_err_sticky = 1'b0;
        w_beat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        push_burst(16'h0030, 8'd7, 2'b00);
        for (int x = 0; x < 8; x++) send_pix(x, 3, 4'h6, 4'h1, 4'(x), w);
        wait_idle();
        check("wr_error clean after reset", 32'(wr_error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
